prog_stream_loader: RTL and testbench
=====================================

Name: prog_stream_loader

Overview:
- Upstream feeder for the program loader / unified system.
- Accepts a framed byte stream (sync, length, payload, optional checksum) over a valid/ready handshake.
- Emits one addressed write strobe per payload byte on the loader's prog_data_in / prog_addr / prog_write_enable interface.
- Raises start_execution once a complete, valid frame has been written.

Parameters:
- DATA_W, 8, stream byte width and program word width
- ADDR_W, 5, program address width
- DEPTH, 32, maximum payload bytes per frame (must be ≤ 2**ADDR_W)
- SYNC_BYTE, 8'hA5, frame start marker

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  block can accept in_data this cycle
- prog_data  out  DATA_W  write data to loader
- prog_addr  out  ADDR_W  write address to loader
- prog_write_enable  out  1  one-cycle write strobe to loader
- start_execution  out  1  level; program in memory is complete and valid
- busy  out  1  frame in progress (state not SYNC/DONE)
- error  out  1  sticky frame error flag

Behaviour:
- Decided: reset is `reset`, asynchronous, active-high; clock is `clock`.
- Reset values of all outputs:
  - in_ready = 1; all other outputs = 0.
  - State = SYNC; address counter = 0; remaining count = 0; checksum accumulator = 0.
- Accept rule: a byte is consumed on a rising edge where in_valid && in_ready. All outputs are registered.
- SYNC state:
  - in_data == SYNC_BYTE → go to LEN, clear error, clear start_execution.
  - Any other byte is discarded; stay in SYNC.
- LEN state: N = in_data.
  - 1 ≤ N ≤ DEPTH → load remaining = N, addr = 0, sum = 0, go to DATA.
  - N == 0 or N > DEPTH → set error, go to SYNC.
- DATA state, per accepted byte:
  - Next cycle: prog_data = byte, prog_addr = addr, prog_write_enable = 1 for exactly 1 cycle.
  - addr++, remaining--, sum += byte (mod 2**DATA_W).
  - When the last byte is accepted (remaining == 1), go to CSUM, or to DONE if the feature is compiled out.
- Write pacing:
  - in_ready = 0 in the cycle prog_write_enable is high, so there is at most one payload byte per 2 cycles.
  - This guarantees a low cycle between strobes so the loader returns to IDLE between writes.
  - prog_data/prog_addr hold their value until the next strobe.
- Address wrap: addr never exceeds N-1 ≤ DEPTH-1; no wrap within a frame.
- DONE state:
  - start_execution = 1, held.
  - in_ready = 1. A SYNC_BYTE starts a new frame: start_execution drops to 0 the next cycle, state goes to LEN. Non-sync bytes are discarded.
- busy = 1 in LEN, DATA, CSUM.
- A stalled stream (in_valid low) simply holds the current state; there is no timeout.
- Reset mid-frame: immediate return to reset values. Partially written memory contents are not undone.

Optional Feature:
- Macro: PROG_STREAM_CHECKSUM_EN.
- Defined:
  - CSUM state accepts one trailing byte.
  - If byte == sum → DONE.
  - Otherwise set error and go to SYNC; start_execution stays 0.
- Undefined:
  - No CSUM state and no accumulator; DATA goes straight to DONE after the last payload byte.
  - error is raised only by bad length.

Decomposition:
- Shared package:
  - State encoding localparams: SYNC = 0, LEN = 1, DATA = 2, CSUM = 3, DONE = 4.
  - Default SYNC_BYTE.
  - Program address/data width constants, shared with the loader and CPU.
- Single module, no sub-module. The checksum accumulator is a few lines under the macro and does not justify a separate block.

Test Plan:
- Frame A5,03,11,22,33 (plus checksum 66 if enabled) → three strobes, (addr,data) = (0,11), (1,22), (2,33); start_execution = 1; error = 0.
- Back-to-back in_valid held high → in_ready low the cycle after each payload accept; strobes separated by ≥ 1 low cycle.
- Garbage 00,FF before A5,01,7E → garbage ignored; single strobe (0,7E); start_execution = 1.
- Length 00, and separately length 21 (hex, 33 > DEPTH) → error = 1, no strobe, state SYNC; next valid frame clears error.
- With PROG_STREAM_CHECKSUM_EN: A5,02,01,02,04 (correct = 03) → two strobes, error = 1, start_execution = 0.
- Reset asserted after second payload byte of a 4-byte frame → all outputs at reset values immediately; a following full frame completes normally.

Source files
------------

// File: rtl/prog_stream_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_stream_loader_pkg
// Description : Shared widths, default frame marker and FSM state encoding
//               for the program stream loader.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_stream_loader_pkg;

    // Program memory geometry, shared with the loader and CPU
    localparam int         PROG_DATA_W       = 8;
    localparam int         PROG_ADDR_W       = 5;
    localparam int         PROG_DEPTH        = 32;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        CSUM = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_stream_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_stream_loader_if
// Description : Byte stream handshake plus loader write bus and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_stream_loader_if #(
    parameter int DATA_W = prog_stream_loader_pkg::PROG_DATA_W,
    parameter int ADDR_W = prog_stream_loader_pkg::PROG_ADDR_W
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] prog_data;
    logic [ADDR_W-1:0] prog_addr;
    logic              prog_write_enable;
    logic              start_execution;
    logic              busy;
    logic              error;

    modport master (
        output in_valid, in_data,
        input  in_ready, prog_data, prog_addr, prog_write_enable,
               start_execution, busy, error
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, prog_data, prog_addr, prog_write_enable,
               start_execution, busy, error
    );
endinterface
`default_nettype wire

// File: rtl/prog_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_stream_loader
// Description : Parses framed byte stream (sync, length, payload[, checksum])
//               into addressed program writes. Optional trailing checksum is
//               enabled by defining PROG_STREAM_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_stream_loader
    import prog_stream_loader_pkg::*;
#(
    parameter int                DATA_W    = PROG_DATA_W,
    parameter int                ADDR_W    = PROG_ADDR_W,
    parameter int                DEPTH     = PROG_DEPTH,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  wire logic           clock,
    input  wire logic           reset,
    prog_stream_loader_if.slave bus
);

    localparam int                c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [DATA_W-1:0] c_depth = DATA_W'(DEPTH);

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_addr, w_addr_next;
    logic [c_cnt_w-1:0]  r_remaining, w_remaining_next;
    logic [DATA_W-1:0]   r_prog_data, w_prog_data_next;
    logic [ADDR_W-1:0]   r_prog_addr, w_prog_addr_next;
    logic                r_write_enable, w_write_enable_next;
    logic                r_in_ready, w_in_ready_next;
    logic                r_start, w_start_next;
    logic                r_error, w_error_next;
    logic                r_busy, w_busy_next;
    logic                w_accept;
`ifdef PROG_STREAM_CHECKSUM_EN
    logic [DATA_W-1:0]   r_sum, w_sum_next;
`endif

    assign w_accept = bus.in_valid && r_in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= SYNC;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_prog_data    <= '0;
            r_prog_addr    <= '0;
            r_write_enable <= 1'b0;
            r_in_ready     <= 1'b1;
            r_start        <= 1'b0;
            r_error        <= 1'b0;
            r_busy         <= 1'b0;
`ifdef PROG_STREAM_CHECKSUM_EN
            r_sum          <= '0;
`endif
        end else begin
            r_state        <= w_state_next;
            r_addr         <= w_addr_next;
            r_remaining    <= w_remaining_next;
            r_prog_data    <= w_prog_data_next;
            r_prog_addr    <= w_prog_addr_next;
            r_write_enable <= w_write_enable_next;
            r_in_ready     <= w_in_ready_next;
            r_start        <= w_start_next;
            r_error        <= w_error_next;
            r_busy         <= w_busy_next;
`ifdef PROG_STREAM_CHECKSUM_EN
            r_sum          <= w_sum_next;
`endif
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_addr_next         = r_addr;
        w_remaining_next    = r_remaining;
        w_prog_data_next    = r_prog_data;
        w_prog_addr_next    = r_prog_addr;
        w_write_enable_next = 1'b0;
        w_start_next        = r_start;
        w_error_next        = r_error;
`ifdef PROG_STREAM_CHECKSUM_EN
        w_sum_next          = r_sum;
`endif

        case (r_state)
            SYNC, DONE: begin
                if (w_accept && (bus.in_data == SYNC_BYTE)) begin
                    w_state_next = LEN;
                    w_error_next = 1'b0;
                    w_start_next = 1'b0;
                end
            end

            LEN: begin
                if (w_accept) begin
                    if ((bus.in_data != '0) && (bus.in_data <= c_depth)) begin
                        w_state_next     = DATA;
                        w_remaining_next = c_cnt_w'(bus.in_data);
                        w_addr_next      = '0;
`ifdef PROG_STREAM_CHECKSUM_EN
                        w_sum_next       = '0;
`endif
                    end else begin
                        w_state_next = SYNC;
                        w_error_next = 1'b1;
                    end
                end
            end

            DATA: begin
                if (w_accept) begin
                    w_prog_data_next    = bus.in_data;
                    w_prog_addr_next    = r_addr;
                    w_write_enable_next = 1'b1;
                    w_addr_next         = r_addr + 1'b1;
                    w_remaining_next    = r_remaining - 1'b1;
`ifdef PROG_STREAM_CHECKSUM_EN
                    w_sum_next          = r_sum + bus.in_data;
                    if (r_remaining == c_cnt_w'(1)) begin
                        w_state_next = CSUM;
                    end
`else
                    if (r_remaining == c_cnt_w'(1)) begin
                        w_state_next = DONE;
                        w_start_next = 1'b1;
                    end
`endif
                end
            end

`ifdef PROG_STREAM_CHECKSUM_EN
            CSUM: begin
                if (w_accept) begin
                    if (bus.in_data == r_sum) begin
                        w_state_next = DONE;
                        w_start_next = 1'b1;
                    end else begin
                        w_state_next = SYNC;
                        w_error_next = 1'b1;
                    end
                end
            end
`endif

            default: begin
                w_state_next = SYNC;
            end
        endcase

        // Blocking the stream during each strobe forces an idle cycle between writes
        w_in_ready_next = !w_write_enable_next;
        w_busy_next     = (w_state_next == LEN) || (w_state_next == DATA) ||
                          (w_state_next == CSUM);
    end

    assign bus.in_ready          = r_in_ready;
    assign bus.prog_data         = r_prog_data;
    assign bus.prog_addr         = r_prog_addr;
    assign bus.prog_write_enable = r_write_enable;
    assign bus.start_execution   = r_start;
    assign bus.busy              = r_busy;
    assign bus.error             = r_error;

endmodule
`default_nettype wire

// File: tb/tb_prog_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_stream_loader
// Description : Directed self-checking bench with write-strobe scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_stream_loader;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic prev_we = 1'b0;
    wr_t  sb[$];
    wr_t  exp_w;

    always #5 clock = ~clock;

    prog_stream_loader_if #(.DATA_W(8), .ADDR_W(5)) bus ();

    prog_stream_loader #(
        .DATA_W    (8),
        .ADDR_W    (5),
        .DEPTH     (32),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [7:0] d);
        sb.push_back('{addr: a, data: d});
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("ready_timeout", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic status(input string tag, input logic s, input logic e, input logic b);
        chk({tag, "_start"}, {31'b0, bus.start_execution}, {31'b0, s});
        chk({tag, "_error"}, {31'b0, bus.error}, {31'b0, e});
        chk({tag, "_busy"},  {31'b0, bus.busy},  {31'b0, b});
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    // Scoreboard consumer and pacing monitor
    always @(negedge clock) begin
        if (!reset && bus.prog_write_enable === 1'b1) begin
            chk("strobe_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_w = sb.pop_front();
                chk("strobe_addr", {27'b0, bus.prog_addr}, {27'b0, exp_w.addr});
                chk("strobe_data", {24'b0, bus.prog_data}, {24'b0, exp_w.data});
            end
            chk("ready_low_on_strobe", {31'b0, bus.in_ready}, 32'd0);
            chk("strobe_gap", {31'b0, prev_we}, 32'd0);
        end
        prev_we = reset ? 1'b0 : bus.prog_write_enable;
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_we", {31'b0, bus.prog_write_enable}, 32'd0);
        chk("rst_pdata", {24'b0, bus.prog_data}, 32'd0);
        chk("rst_paddr", {27'b0, bus.prog_addr}, 32'd0);
        status("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Basic frame, in_valid held high throughout
        expect_wr(5'd0, 8'h11);
        expect_wr(5'd1, 8'h22);
        expect_wr(5'd2, 8'h33);
        send(8'hA5);
        chk("busy_after_sync", {31'b0, bus.busy}, 32'd1);
        send(8'h03);
        send(8'h11);
        chk("ready_after_payload", {31'b0, bus.in_ready}, 32'd0);
        send(8'h22);
        send(8'h33);
`ifdef PROG_STREAM_CHECKSUM_EN
        send(8'h66);
`endif
        idle(4);
        status("frameA", 1'b1, 1'b0, 1'b0);

        // Garbage ignored while DONE, new sync drops start_execution
        send(8'h00);
        send(8'hFF);
        chk("garbage_keeps_start", {31'b0, bus.start_execution}, 32'd1);
        expect_wr(5'd0, 8'h7E);
        send(8'hA5);
        chk("sync_drops_start", {31'b0, bus.start_execution}, 32'd0);
        send(8'h01);
        send(8'h7E);
`ifdef PROG_STREAM_CHECKSUM_EN
        send(8'h7E);
`endif
        idle(4);
        status("frameB", 1'b1, 1'b0, 1'b0);

        // Zero length
        send(8'hA5);
        send(8'h00);
        idle(3);
        status("len0", 1'b0, 1'b1, 1'b0);
        chk("len0_ready", {31'b0, bus.in_ready}, 32'd1);

        // Recovery frame clears error
        expect_wr(5'd0, 8'h55);
        send(8'hA5);
        chk("sync_clears_error", {31'b0, bus.error}, 32'd0);
        send(8'h01);
        send(8'h55);
`ifdef PROG_STREAM_CHECKSUM_EN
        send(8'h55);
`endif
        idle(4);
        status("frameC", 1'b1, 1'b0, 1'b0);

        // Length above DEPTH
        send(8'hA5);
        send(8'h21);
        idle(3);
        status("len33", 1'b0, 1'b1, 1'b0);

        expect_wr(5'd0, 8'h01);
        expect_wr(5'd1, 8'h02);
        send(8'hA5);
        send(8'h02);
        send(8'h01);
        send(8'h02);
`ifdef PROG_STREAM_CHECKSUM_EN
        send(8'h03);
`endif
        idle(4);
        status("frameD", 1'b1, 1'b0, 1'b0);

`ifdef PROG_STREAM_CHECKSUM_EN
        // Bad checksum: payload written but frame rejected
        expect_wr(5'd0, 8'h01);
        expect_wr(5'd1, 8'h02);
        send(8'hA5);
        send(8'h02);
        send(8'h01);
        send(8'h02);
        send(8'h04);
        idle(4);
        status("badsum", 1'b0, 1'b1, 1'b0);
`endif

        // Reset after the second payload byte of a 4-byte frame
        expect_wr(5'd0, 8'hAA);
        expect_wr(5'd1, 8'hBB);
        send(8'hA5);
        send(8'h04);
        send(8'hAA);
        send(8'hBB);
        bus.in_valid = 1'b0;
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("midrst_we", {31'b0, bus.prog_write_enable}, 32'd0);
        chk("midrst_pdata", {24'b0, bus.prog_data}, 32'd0);
        chk("midrst_paddr", {27'b0, bus.prog_addr}, 32'd0);
        status("midrst", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        expect_wr(5'd0, 8'h01);
        expect_wr(5'd1, 8'h02);
        expect_wr(5'd2, 8'h03);
        expect_wr(5'd3, 8'h04);
        send(8'hA5);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
`ifdef PROG_STREAM_CHECKSUM_EN
        send(8'h0A);
`endif
        idle(4);
        status("frameE", 1'b1, 1'b0, 1'b0);
        chk("final_paddr", {27'b0, bus.prog_addr}, 32'd3);
        chk("final_pdata", {24'b0, bus.prog_data}, 32'h04);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
